// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10
    } mdu_state_e;

    localparam int MDU_ITERS = 32;

    function automatic logic [31:0] absVal(input logic [31:0] v, input logic isSigned);
        return (isSigned && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the register file and the multiply/divide unit.
// The HI/LO write-back group exists only when MDU_HILO_WRITE_EN is defined.
interface mult_div_unit_if;
    import mdu_pkg::*;

    logic        Start;
    mdu_op_e     Op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;
`ifdef MDU_HILO_WRITE_EN
    logic        HiWE;
    logic        LoWE;
    logic [31:0] WriteData;
`endif

    modport master (
        output Start, Op, SrcA, SrcB,
`ifdef MDU_HILO_WRITE_EN
        output HiWE, LoWE, WriteData,
`endif
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  Start, Op, SrcA, SrcB,
`ifdef MDU_HILO_WRITE_EN
        input  HiWE, LoWE, WriteData,
`endif
        output Busy, Done, HI, LO
    );

endinterface

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add for multiply, trial subtract/restore for divide.
// Accumulator is {HI half, LO half}; divide leaves remainder high and quotient low.
module mdu_iter_step (
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    input  logic        isDiv,
    output logic [63:0] accNxt
);
    logic [32:0] addSum;
    logic [32:0] remSh;
    logic [32:0] remDiff;

    always_comb begin
        addSum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        remSh   = acc[63:31];
        remDiff = remSh - {1'b0, opnd};
        accNxt  = {addSum, acc[31:1]};
        if (isDiv) begin
            if (remSh >= {1'b0, opnd}) begin
                accNxt = {remDiff[31:0], acc[30:0], 1'b1};
            end else begin
                accNxt = {remSh[31:0], acc[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: 34 cycles accept-to-accept, Start ignored while Busy.
// MDU_HILO_WRITE_EN adds MTHI/MTLO writes, honoured only in IDLE.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic            CLK,
    input  logic            RST_N,
    mult_div_unit_if.slave  bus
);
    mdu_state_e  state, stateNxt;
    logic [4:0]  iterCnt;
    logic [63:0] acc, accNxt;
    logic [31:0] opnd;
    logic [31:0] srcAReg;
    logic        isDiv, negRes, negRem, divZero;
    logic [31:0] hiReg, loReg;
    logic        doneReg;
    logic        opSigned;
    logic [31:0] aMag, bMag;
    logic [31:0] hiRes, loRes;
    logic [63:0] prodRes;

    assign opSigned = ~bus.Op[0];
    assign aMag     = absVal(bus.SrcA, opSigned);
    assign bMag     = absVal(bus.SrcB, opSigned);

    mdu_iter_step u_step (
        .acc    (acc),
        .opnd   (opnd),
        .isDiv  (isDiv),
        .accNxt (accNxt)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (bus.Start) stateNxt = CALC;
            CALC:    if (iterCnt == 5'(MDU_ITERS - 1)) stateNxt = SIGN;
            SIGN:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Divide by zero bypasses sign fix-up and reports the raw dividend.
    always_comb begin
        prodRes = negRes ? (64'd0 - acc) : acc;
        hiRes   = prodRes[63:32];
        loRes   = prodRes[31:0];
        if (divZero) begin
            hiRes = srcAReg;
            loRes = 32'hFFFF_FFFF;
        end else if (isDiv) begin
            hiRes = negRem ? (32'd0 - acc[63:32]) : acc[63:32];
            loRes = negRes ? (32'd0 - acc[31:0])  : acc[31:0];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            iterCnt <= '0;
            acc     <= '0;
            opnd    <= '0;
            srcAReg <= '0;
            isDiv   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= (state == SIGN);
            case (state)
                IDLE: begin
`ifdef MDU_HILO_WRITE_EN
                    if (bus.HiWE) hiReg <= bus.WriteData;
                    if (bus.LoWE) loReg <= bus.WriteData;
`endif
                    if (bus.Start) begin
                        isDiv   <= bus.Op[1];
                        opnd    <= bus.Op[1] ? bMag : aMag;
                        acc     <= {32'd0, (bus.Op[1] ? aMag : bMag)};
                        negRes  <= opSigned & (bus.SrcA[31] ^ bus.SrcB[31]);
                        negRem  <= opSigned & bus.SrcA[31];
                        divZero <= bus.Op[1] & (bus.SrcB == 32'd0);
                        srcAReg <= bus.SrcA;
                        iterCnt <= '0;
                    end
                end
                CALC: begin
                    acc     <= accNxt;
                    iterCnt <= iterCnt + 5'd1;
                end
                SIGN: begin
                    hiReg <= hiRes;
                    loReg <= loRes;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy = (state != IDLE);
    assign bus.Done = doneReg;
    assign bus.HI   = hiReg;
    assign bus.LO   = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model with per-cycle compare plus directed literals.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   cmpEn = 1'b0;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from the MIPS definitions.
    function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, sp, sq, sr;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
            2'b01: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
            2'b10: begin
                if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin sq = sa / sb; sr = sa % sb; hi = sr[31:0]; lo = sq[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin hi = a % b; lo = a / b; end
            end
        endcase
    endfunction

    // Model: remaining busy cycles, pending result, visible HI/LO.
    int          mCnt = 0;
    logic        mDone = 1'b0;
    logic [31:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mCnt = 0; mDone = 1'b0; mHi = '0; mLo = '0;
        end else begin
            mDone = 1'b0;
            if (mCnt != 0) begin
                mCnt--;
                if (mCnt == 0) begin mHi = pHi; mLo = pLo; mDone = 1'b1; end
            end else begin
`ifdef MDU_HILO_WRITE_EN
                if (bus.HiWE) mHi = bus.WriteData;
                if (bus.LoWE) mLo = bus.WriteData;
`endif
                if (bus.Start) begin
                    refModel(bus.Op, bus.SrcA, bus.SrcB, pHi, pLo);
                    mCnt = 33;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (cmpEn && RST_N) begin
            check("cyc_busy", 64'(bus.Busy), 64'(mCnt != 0));
            check("cyc_done", 64'(bus.Done), 64'(mDone));
            check("cyc_hi", 64'(bus.HI), 64'(mHi));
            check("cyc_lo", 64'(bus.LO), 64'(mLo));
        end
    end

    task automatic doOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit chk, input logic [31:0] eHi, input logic [31:0] eLo,
                        input int injectAt, input int resetAt, input int weAt);
        int          doneAt;
        int          busyCnt;
        int          guard;
        logic [31:0] hiBefore;
        guard = 0;
        while (bus.Busy && guard < 100) begin @(negedge CLK); guard++; end
        @(negedge CLK);
        bus.Start = 1'b1;
        bus.Op    = mdu_op_e'(op);
        bus.SrcA  = a;
        bus.SrcB  = b;
        hiBefore  = bus.HI;
        doneAt    = 0;
        busyCnt   = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLK);
            bus.Start = 1'b0;
            bus.SrcA  = $urandom;
            bus.SrcB  = $urandom;
            if (n == injectAt) begin
                bus.Start = 1'b1; bus.Op = MDU_MULTU; bus.SrcA = 32'd2; bus.SrcB = 32'd3;
            end
`ifdef MDU_HILO_WRITE_EN
            if (n == weAt) begin
                bus.HiWE = 1'b1; bus.WriteData = 32'hDEAD_BEEF;
            end else if (n == weAt + 1) begin
                bus.HiWE = 1'b0;
                #1 check("hiwe_busy_ignored", 64'(bus.HI), 64'(hiBefore));
            end
`endif
            if (n == resetAt) begin
                RST_N = 1'b0;
                #1;
                check("rst_busy", 64'(bus.Busy), 64'd0);
                check("rst_done", 64'(bus.Done), 64'd0);
                check("rst_hi", 64'(bus.HI), 64'd0);
                check("rst_lo", 64'(bus.LO), 64'd0);
                @(negedge CLK);
                RST_N = 1'b1;
                return;
            end
            if (bus.Busy) busyCnt++;
            if (bus.Done) begin doneAt = n; break; end
        end
        check("done_latency", 64'(doneAt), 64'd34);
        if (chk) begin
            check("busy_cycles", 64'(busyCnt), 64'd33);
            check("res_hi", 64'(bus.HI), 64'(eHi));
            check("res_lo", 64'(bus.LO), 64'(eLo));
        end
    endtask

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Start = 1'b0;
        bus.Op    = MDU_MULT;
        bus.SrcA  = '0;
        bus.SrcB  = '0;
`ifdef MDU_HILO_WRITE_EN
        bus.HiWE      = 1'b0;
        bus.LoWE      = 1'b0;
        bus.WriteData = '0;
`endif
        repeat (3) @(negedge CLK);
        #1;
        check("reset_busy", 64'(bus.Busy), 64'd0);
        check("reset_done", 64'(bus.Done), 64'd0);
        check("reset_hi", 64'(bus.HI), 64'd0);
        check("reset_lo", 64'(bus.LO), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        cmpEn = 1'b1;

        doOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, 0);
        doOp(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 10, 0, 0);
        doOp(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 0);
        doOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, 0, 0, 0);
        doOp(2'b11, 32'd100, 32'd0, 1'b1, 32'h0000_0064, 32'hFFFF_FFFF, 0, 0, 0);
        doOp(2'b11, 32'd1000, 32'd7, 1'b0, 32'd0, 32'd0, 0, 20, 0);
        doOp(2'b11, 32'd1000, 32'd7, 1'b1, 32'd6, 32'd142, 0, 0, 0);

`ifdef MDU_HILO_WRITE_EN
        @(negedge CLK);
        bus.HiWE = 1'b1;
        bus.WriteData = 32'h1234_5678;
        @(negedge CLK);
        bus.HiWE = 1'b0;
        #1 check("hiwe_idle", 64'(bus.HI), 64'h1234_5678);
        doOp(2'b01, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 0, 0, 5);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb, eh, el;
            logic [1:0]  rop;
            rop = 2'($urandom_range(0, 3));
            ra  = pickVal();
            rb  = pickVal();
            refModel(rop, ra, rb, eh, el);
            doOp(rop, ra, rb, 1'b1, eh, el, (i % 5 == 0) ? 7 : 0, 0, 0);
        end

        repeat (3) @(negedge CLK);
        cmpEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
